// File: rtl/bit_serializer_pkg.sv
// Shared types and constants for the bit_serializer transmit path.
// Holds the FSM state encoding, the completed-word counter width and a sizing helper.
package bit_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam int COUNT_W = 16;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int bits_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bit_serializer_sclk_gen.sv
// Bit-clock generator: phase counter producing oSCLK plus end-of-phase and end-of-bit strobes.
// oSCLK is low for the first phase of each bit and high for the second.
module sclk_gen
  import bit_serializer_pkg::*;
#(
  parameter int HALF_PERIOD = 1
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic i_enable,
  input  logic i_restart,
  output logic o_sclk,
  output logic o_phase_end,
  output logic o_bit_end
);

  localparam int PW = bits_for(HALF_PERIOD);
  localparam logic [PW-1:0] LAST_PHASE = PW'(HALF_PERIOD - 1);

  logic [PW-1:0] r_phase;
  logic          r_sclk;
  logic          w_phase_end;

  assign w_phase_end = i_enable && (r_phase == LAST_PHASE);

  // A bit ends when its high phase completes.
  assign o_bit_end   = w_phase_end && r_sclk;
  assign o_phase_end = w_phase_end;
  assign o_sclk      = r_sclk;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_phase <= '0;
      r_sclk  <= 1'b0;
    end else if (i_restart) begin
      r_phase <= '0;
      r_sclk  <= 1'b0;
    end else if (i_enable) begin
      if (w_phase_end) begin
        r_phase <= '0;
        r_sclk  <= ~r_sclk;
      end else begin
        r_phase <= r_phase + PW'(1);
      end
    end
  end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial transmitter: LSB-first data on oBit with a generated bit clock oSCLK.
// Define BIT_SERIALIZER_PARITY_EN to append an even-parity bit after each word.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int HALF_PERIOD = 1,
  parameter int GAP_CYCLES  = 0
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic [WIDTH-1:0]   iData,
  input  logic               iValid,
  output logic               oReady,
  output logic               oBit,
  output logic               oSCLK,
  output logic               oFrame,
  output logic               oDone,
  output logic [COUNT_W-1:0] oCount,
  output state_t             oState
);

  // Handshake: a word is taken when iValid && oReady at posedge; oReady is
  // low exactly while the holding register is occupied, and iValid is ignored then.

`ifdef BIT_SERIALIZER_PARITY_EN
  localparam int SW = WIDTH + 1;
`else
  localparam int SW = WIDTH;
`endif
  localparam int IW = $clog2(WIDTH + 1);
  localparam int GW = bits_for(GAP_CYCLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(SW - 1);
  localparam logic [GW-1:0] LAST_GAP = GW'(GAP_CYCLES - 1);

  state_t               r_state;
  logic [WIDTH-1:0]     r_hold;
  logic                 r_hold_full;
  logic [SW-1:0]        r_shift;
  logic [IW-1:0]        r_bit_idx;
  logic                 r_frame;
  logic                 r_done;
  logic [COUNT_W-1:0]   r_count;
  logic [GW-1:0]        r_gap;

  logic                 w_sclk;
  logic                 w_phase_end;
  logic                 w_bit_end;
  logic                 w_last;
  logic                 w_word_end;
  logic                 w_load;
  logic                 w_accept;
  logic [SW-1:0]        w_load_word;

`ifdef BIT_SERIALIZER_PARITY_EN
  // Parity rides at the top of the shift register so it leaves last.
  assign w_load_word = {^r_hold, r_hold};
`else
  assign w_load_word = r_hold;
`endif

  assign w_accept   = iValid && !r_hold_full;
  assign w_last     = (r_bit_idx == LAST_IDX);
  assign w_word_end = w_bit_end && w_last;
  // Reload straight from the last bit only when no gap is required.
  assign w_load     = ((r_state == ST_IDLE) && r_hold_full) ||
                      (w_word_end && (GAP_CYCLES == 0) && r_hold_full);

  sclk_gen #(
    .HALF_PERIOD (HALF_PERIOD)
  ) u_sclk_gen (
    .iCLK        (iCLK),
    .iRST        (iRST),
    .i_enable    (r_state == ST_SHIFT),
    .i_restart   (w_load),
    .o_sclk      (w_sclk),
    .o_phase_end (w_phase_end),
    .o_bit_end   (w_bit_end)
  );

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else if (w_load) begin
      r_hold_full <= 1'b0;
    end else if (w_accept) begin
      r_hold      <= iData;
      r_hold_full <= 1'b1;
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_frame   <= 1'b0;
      r_done    <= 1'b0;
      r_count   <= '0;
      r_gap     <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_shift   <= w_load_word;
        r_bit_idx <= '0;
        r_frame   <= 1'b1;
        r_state   <= ST_SHIFT;
      end else begin
        case (r_state)
          ST_SHIFT: begin
            if (w_bit_end) begin
              if (w_last) begin
                r_frame <= 1'b0;
                r_shift <= '0;
                if (GAP_CYCLES > 0) begin
                  r_state <= ST_GAP;
                  r_gap   <= '0;
                end else begin
                  r_state <= ST_IDLE;
                end
              end else begin
                r_shift   <= {1'b0, r_shift[SW-1:1]};
                r_bit_idx <= r_bit_idx + IW'(1);
              end
            end
          end
          ST_GAP: begin
            if (r_gap == LAST_GAP) begin
              r_state <= ST_IDLE;
            end else begin
              r_gap <= r_gap + GW'(1);
            end
          end
          default: ;
        endcase
      end
      if (w_word_end) begin
        r_done  <= 1'b1;
        r_count <= r_count + COUNT_W'(1);
      end
    end
  end

  assign oReady = ~r_hold_full;
  assign oBit   = r_shift[0];
  assign oSCLK  = w_sclk;
  assign oFrame = r_frame;
  assign oDone  = r_done;
  assign oCount = r_count;
  assign oState = r_state;

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: directed words, serial capture on oSCLK rise.
// Handles both default and BIT_SERIALIZER_PARITY_EN builds.
module tb_bit_serializer;
  import bit_serializer_pkg::*;

`ifdef BIT_SERIALIZER_PARITY_EN
  localparam int NB = 33;
`else
  localparam int NB = 32;
`endif

  logic        iCLK = 1'b0;
  logic        iRST = 1'b0;
  logic [31:0] iData = '0;
  logic        iValid = 1'b0;
  logic        oReady, oBit, oSCLK, oFrame, oDone;
  logic [15:0] oCount;
  state_t      oState;

  logic [NB-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int last_run = 0;
  logic [NB-1:0] last_word = '0;

  bit_serializer #(.WIDTH(32), .HALF_PERIOD(1), .GAP_CYCLES(0)) dut (
    .iCLK(iCLK), .iRST(iRST), .iData(iData), .iValid(iValid), .oReady(oReady),
    .oBit(oBit), .oSCLK(oSCLK), .oFrame(oFrame), .oDone(oDone), .oCount(oCount),
    .oState(oState)
  );

  always #5 iCLK = ~iCLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Collects bits on each oSCLK rise inside a frame and scores whole words.
  task automatic monitor();
    logic prev_sclk = 1'b0;
    int nb = 0;
    int run = 0;
    logic [NB-1:0] w = '0;
    forever begin
      @(negedge iCLK);
      if (!iRST) begin
        nb = 0;
        run = 0;
        prev_sclk = 1'b0;
      end else begin
        if (oFrame) run++;
        else if (run != 0) begin
          last_run = run;
          run = 0;
        end
        if (oDone) done_cnt++;
        if (oSCLK && !prev_sclk && oFrame) begin
          w[nb] = oBit;
          nb++;
          if (nb == NB) begin
            nb = 0;
            last_word = w;
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_word: got 0x%0h expected none", w);
            end else begin
              check("word", w, exp_q.pop_front());
            end
          end
        end
        prev_sclk = oSCLK;
      end
    end
  endtask

  function automatic logic [NB-1:0] expect_of(input logic [31:0] d);
`ifdef BIT_SERIALIZER_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  // Enters and leaves at a negedge; iValid stays high on return.
  task automatic send(input logic [31:0] d);
    int t = 0;
    iData = d;
    iValid = 1'b1;
    while (!oReady && t < 500) begin
      @(negedge iCLK);
      t++;
    end
    check("send_ready_timeout", t >= 500, 0);
    @(posedge iCLK);
    exp_q.push_back(expect_of(d));
    @(negedge iCLK);
  endtask

  task automatic wait_done(input int target, input string name);
    int t = 0;
    while (done_cnt < target && t < 3000) begin
      @(negedge iCLK);
      t++;
    end
    repeat (4) @(negedge iCLK);
    check(name, done_cnt, target);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_oBit"}, oBit, 0);
    check({tag, "_oSCLK"}, oSCLK, 0);
    check({tag, "_oFrame"}, oFrame, 0);
    check({tag, "_oReady"}, oReady, 1);
    check({tag, "_oDone"}, oDone, 0);
    check({tag, "_oCount"}, oCount, 0);
    check({tag, "_state"}, oState, ST_IDLE);
  endtask

  initial begin
    int base;
    fork
      monitor();
    join_none

    // Reset
    repeat (3) @(negedge iCLK);
    check_reset_values("reset");
    iRST = 1'b1;
    repeat (2) @(negedge iCLK);

    // Single word, latency and frame length
    send(32'hA5A5_0F0F);
    iValid = 1'b0;
    check("lat_frame_before", oFrame, 0);
    check("lat_ready_low", oReady, 0);
    @(negedge iCLK);
    check("lat_frame_up", oFrame, 1);
    check("lat_bit0", oBit, 1);
    check("lat_sclk_low", oSCLK, 0);
    check("lat_ready_back", oReady, 1);
    wait_done(1, "single_done");
    check("single_run", last_run, NB * 2);
    check("single_count", oCount, 16'd1);
    check("single_low_byte", last_word[7:0], 8'h0F);

    // Four words back-to-back
    send(32'h1234_5678);
    send(32'hDEAD_BEEF);
    check("hold_full_ready", oReady, 0);
    send(32'h0000_FFFF);
    send(32'h8000_0001);
    iValid = 1'b0;
    wait_done(5, "stream_done");
    check("stream_run", last_run, 4 * NB * 2);
    check("stream_count", oCount, 16'd5);

    // Offer while oReady=0 must be ignored
    send(32'h1111_1111);
    send(32'h2222_2222);
    iData = 32'hCAFE_F00D;
    check("busy_ready_low", oReady, 0);
    repeat (8) @(negedge iCLK);
    iValid = 1'b0;
    wait_done(7, "ignore_done");
    repeat (150) @(negedge iCLK);
    check("ignore_no_extra", done_cnt, 7);
    check("ignore_count", oCount, 16'd7);

    // Reset during bit 10 of an all-ones word
    send(32'hFFFF_FFFF);
    iValid = 1'b0;
    repeat (21) @(negedge iCLK);
    check("abort_mid_frame", oFrame, 1);
    iRST = 1'b0;
    exp_q.delete();
    @(negedge iCLK);
    check_reset_values("abort");
    iRST = 1'b1;
    @(negedge iCLK);
    base = done_cnt;
    send(32'h0000_0001);
    iValid = 1'b0;
    wait_done(base + 1, "after_abort_done");
    check("after_abort_count", oCount, 16'd1);
    check("after_abort_run", last_run, NB * 2);
`ifdef BIT_SERIALIZER_PARITY_EN
    check("parity_of_1", last_word[32], 1);
    send(32'h0000_0003);
    iValid = 1'b0;
    wait_done(base + 2, "parity3_done");
    check("parity_of_3", last_word[32], 0);
    check("parity3_run", last_run, 66);
`endif

    // Counter wrap
    force dut.r_count = 16'hFFFF;
    @(negedge iCLK);
    release dut.r_count;
    base = done_cnt;
    send(32'h5A5A_5A5A);
    iValid = 1'b0;
    wait_done(base + 1, "wrap_done");
    check("wrap_count", oCount, 16'h0000);

    check("pending_words", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
